// File: rtl/mips_soc_top_pkg.sv
// Shared types for the MIPS32 subset system: opcodes, ALU ops, decode control.
// Consumed by the decoder, the core and the top (MIPS_SOC_TRACE_EN adds a retire trace in the core).
package selector;

  typedef enum logic [1:0] {
    EXC_CHK_NONE    = 2'd0,
    EXC_CHK_SYSCALL = 2'd1,
    EXC_CHK_RI      = 2'd2
  } execption_check_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    alu_op_t          alu_op;
    logic             alu_src;
    logic             zero_ext;
    logic             reg_dst;
    logic             branch;
    logic             branch_ne;
    logic             jump;
    logic             jump_reg;
    logic             link;
    execption_check_t exc_chk;
  } control_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    control_t    control;
  } decode_sig_t;

  localparam control_t CTRL_NOP = '0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_soc_top_if.sv
// Decode-stage bundle: current instruction, its PC and the decoded control word.
interface pif_decode_if;
  import selector::*;
  decode_sig_t signal_out;
endinterface

// File: rtl/mips_soc_top_core.sv
// Single-cycle MIPS32 subset core: PC, decode/GPR file, ALU, next-PC and writeback.
// MIPS_SOC_TRACE_EN prints one line per retired instruction.
module mips_core
  import selector::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
);
  pif_decode_if pif_decode ();

  control_t    c;
  logic [31:0] ir, rs_val, rt_val, imm_ext, alu_b, alu_y, wd, pc4, pc_next;
  logic [4:0]  shamt;
  logic        unused_ir;

  mips_decode unit_decode (
    .clk     (clk),
    .rst_n   (rst_n),
    .instr   (instr),
    .pc      (pc),
    .wd      (wd),
    .pif     (pif_decode),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .imm_ext (imm_ext)
  );

  assign c     = pif_decode.signal_out.control;
  assign ir    = pif_decode.signal_out.instr;
  assign pc4   = pif_decode.signal_out.pc + 32'd4;
  assign shamt = ir[10:6];
  assign unused_ir = ^{ir[31:26], c};

  always_comb begin
    alu_b = c.alu_src ? imm_ext : rt_val;
    case (c.alu_op)
      ALU_ADD:  alu_y = rs_val + alu_b;
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_XOR:  alu_y = rs_val ^ alu_b;
      ALU_NOR:  alu_y = ~(rs_val | alu_b);
      ALU_SLT:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'd0, rs_val < alu_b};
      ALU_SLL:  alu_y = rt_val << shamt;
      ALU_SRL:  alu_y = rt_val >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(rt_val) >>> shamt);
      ALU_LUI:  alu_y = {imm_ext[15:0], 16'h0};
      default:  alu_y = rs_val + alu_b;
    endcase
  end

  assign dmem_addr  = alu_y;
  assign dmem_wdata = rt_val;
  assign dmem_we    = c.mem_write;
  assign wd         = c.link ? pc4 : (c.mem_to_reg ? dmem_rdata : alu_y);

  always_comb begin
    pc_next = pc4;
    if (c.jump_reg)
      pc_next = rs_val;
    else if (c.jump)
      pc_next = {pc4[31:28], ir[25:0], 2'b00};
    else if (c.branch && ((rs_val == rt_val) != c.branch_ne))
      pc_next = pc4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

`ifdef MIPS_SOC_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      $display("pc=%h instr=%h wr=%h", pc, ir, c.reg_write ? wd : 32'h0);
      if (c.exc_chk == EXC_CHK_SYSCALL)
        $display("syscall v0=%h", unit_decode.unit_rf.file[2]);
    end
  end
`endif
endmodule

// File: rtl/mips_soc_top_decode.sv
// Instruction decoder with the 2R1W GPR file; publishes its result on pif_decode_if.
module mips_rf
  import selector::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] file [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) file[i] <= '0;
    end else if (we && wa != 5'd0) begin
      file[wa] <= wd;
    end
  end

  // Reads are combinational, so a same-cycle write is seen only next cycle.
  assign rd1 = (ra1 == 5'd0) ? '0 : file[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : file[ra2];
endmodule

module mips_decode
  import selector::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] wd,
  pif_decode_if       pif,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] imm_ext
);
  control_t   ctrl;
  logic [5:0] op, funct;
  logic [4:0] wa;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          F_ADDU:    ctrl.alu_op = ALU_ADD;
          F_SUBU:    ctrl.alu_op = ALU_SUB;
          F_AND:     ctrl.alu_op = ALU_AND;
          F_OR:      ctrl.alu_op = ALU_OR;
          F_XOR:     ctrl.alu_op = ALU_XOR;
          F_NOR:     ctrl.alu_op = ALU_NOR;
          F_SLT:     ctrl.alu_op = ALU_SLT;
          F_SLTU:    ctrl.alu_op = ALU_SLTU;
          F_SLL:     ctrl.alu_op = ALU_SLL;
          F_SRL:     ctrl.alu_op = ALU_SRL;
          F_SRA:     ctrl.alu_op = ALU_SRA;
          F_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jump_reg  = 1'b1;
          end
          F_SYSCALL: begin
            ctrl.reg_write = 1'b0;
            ctrl.exc_chk   = EXC_CHK_SYSCALL;
          end
          default: begin
            ctrl.reg_write = 1'b0;
            ctrl.exc_chk   = EXC_CHK_RI;
          end
        endcase
      end
      OP_ADDIU: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;  end
      OP_SLTI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_SLT;  end
      OP_SLTIU: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_SLTU; end
      OP_ANDI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_ORI:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_XORI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_XOR; end
      OP_LUI:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_LUI;  end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_BNE: begin ctrl.branch = 1'b1; ctrl.branch_ne = 1'b1; end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_write = 1'b1; end
      default: ctrl.exc_chk = EXC_CHK_RI;
    endcase
  end

  assign wa      = ctrl.link ? 5'd31 : (ctrl.reg_dst ? instr[15:11] : instr[20:16]);
  assign imm_ext = ctrl.zero_ext ? {16'h0, instr[15:0]} : sext16(instr[15:0]);

  mips_rf unit_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (ctrl.reg_write),
    .wa    (wa),
    .wd    (wd)
  );

  assign pif.signal_out = '{instr: instr, pc: pc, control: ctrl};
endmodule

// File: rtl/mips_soc_top.sv
// Simulation top: one mips_core with word-addressed instruction ROM and data RAM.
// Define MIPS_SOC_TRACE_EN to get a per-instruction retire trace from the core.
module mips_soc_top
  import selector::*;
#(
  parameter string       IMEM_FILE  = "imem.hex",
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic [31:0] pc, instr, daddr, dwdata, drdata;
  logic        dwe, unused_addr;

  mips_core #(.RESET_PC(RESET_PC)) unit_core (
    .clk        (clk),
    .rst_n      (reset),
    .pc         (pc),
    .instr      (instr),
    .dmem_addr  (daddr),
    .dmem_wdata (dwdata),
    .dmem_we    (dwe),
    .dmem_rdata (drdata)
  );

  assign instr  = imem[pc[IW+1:2]];
  assign drdata = dmem[daddr[DW+1:2]];
  assign unused_addr = ^{pc[31:IW+2], pc[1:0], daddr[31:DW+2], daddr[1:0]};

  // RAM contents survive reset; stores are suppressed while it is held.
  always_ff @(posedge clk) begin
    if (reset && dwe) dmem[daddr[DW+1:2]] <= dwdata;
  end
endmodule

// File: tb/tb_mips_soc_top.sv
// Bench for mips_soc_top: table of single instructions run as one program, plus loop and call sequences.
module tb_mips_soc_top;
  import selector::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mips_soc_top #(.IMEM_FILE("")) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      instr;
    logic [4:0]       dst;
    logic [31:0]      val;
    execption_check_t exc;
  } vec_t;

  typedef struct {
    logic [4:0]       dst;
    logic [31:0]      val;
    execption_check_t exc;
    logic [31:0]      pc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] enc_r(logic [5:0] f, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, f};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, input logic [4:0] dst, input logic [31:0] val,
                     input execption_check_t exc);
    vec_t v;
    v.instr = instr; v.dst = dst; v.val = val; v.exc = exc;
    vecs.push_back(v);
  endtask

  task automatic load(input logic [31:0] p[$]);
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0;
    foreach (p[i]) dut.imem[i] = p[i];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int nonzero_gprs();
    int n = 0;
    for (int r = 1; r < 32; r++)
      if (dut.unit_core.unit_decode.unit_rf.file[r] !== 32'h0) n++;
    return n;
  endfunction

  task automatic run_sys(output int cyc, output bit hit);
    cyc = 0;
    hit = 1'b0;
    while (cyc < 200) begin
      if (dut.unit_core.pif_decode.signal_out.control.exc_chk == EXC_CHK_SYSCALL) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    exp_t e;
    int   cyc, k;
    bit   hit;

    // Straight-line vectors: {instr, checked GPR, value after retire, decode exc_chk}
    add(enc_i(6'h09, 0, 8, 16'h7FFF),    8,  32'h0000_7FFF, EXC_CHK_NONE);
    add(enc_i(6'h09, 0, 9, 16'hFFFF),    9,  32'hFFFF_FFFF, EXC_CHK_NONE);
    add(enc_r(6'h21, 8, 9, 10, 0),       10, 32'h0000_7FFE, EXC_CHK_NONE);
    add(enc_r(6'h23, 0, 8, 11, 0),       11, 32'hFFFF_8001, EXC_CHK_NONE);
    add(enc_i(6'h0F, 0, 12, 16'h8000),   12, 32'h8000_0000, EXC_CHK_NONE);
    add(enc_r(6'h03, 0, 12, 13, 4),      13, 32'hF800_0000, EXC_CHK_NONE);
    add(enc_r(6'h02, 0, 12, 14, 4),      14, 32'h0800_0000, EXC_CHK_NONE);
    add(enc_r(6'h00, 0, 8, 15, 16),      15, 32'h7FFF_0000, EXC_CHK_NONE);
    add(enc_r(6'h2A, 12, 8, 16, 0),      16, 32'h0000_0001, EXC_CHK_NONE);
    add(enc_r(6'h2B, 12, 8, 17, 0),      17, 32'h0000_0000, EXC_CHK_NONE);
    add(enc_i(6'h0A, 9, 18, 16'h0000),   18, 32'h0000_0001, EXC_CHK_NONE);
    add(enc_i(6'h0B, 8, 19, 16'hFFFF),   19, 32'h0000_0001, EXC_CHK_NONE);
    add(enc_i(6'h0C, 9, 20, 16'hF0F0),   20, 32'h0000_F0F0, EXC_CHK_NONE);
    add(enc_i(6'h0D, 12, 21, 16'h8001),  21, 32'h8000_8001, EXC_CHK_NONE);
    add(enc_i(6'h0E, 9, 22, 16'hFFFF),   22, 32'hFFFF_0000, EXC_CHK_NONE);
    add(enc_r(6'h27, 0, 8, 23, 0),       23, 32'hFFFF_8000, EXC_CHK_NONE);
    add(enc_r(6'h24, 9, 12, 24, 0),      24, 32'h8000_0000, EXC_CHK_NONE);
    add(enc_r(6'h25, 8, 12, 25, 0),      25, 32'h8000_7FFF, EXC_CHK_NONE);
    add(enc_r(6'h26, 9, 8, 3, 0),        3,  32'hFFFF_8000, EXC_CHK_NONE);
    add(enc_i(6'h0F, 0, 8, 16'h1234),    8,  32'h1234_0000, EXC_CHK_NONE);
    add(enc_i(6'h0D, 8, 8, 16'h5678),    8,  32'h1234_5678, EXC_CHK_NONE);
    add(enc_i(6'h2B, 0, 8, 16'h0004),    8,  32'h1234_5678, EXC_CHK_NONE);
    add(enc_i(6'h23, 0, 9, 16'h0004),    9,  32'h1234_5678, EXC_CHK_NONE);
    add(enc_i(6'h23, 0, 10, 16'h1004),   10, 32'h1234_5678, EXC_CHK_NONE);
    add(enc_r(6'h21, 9, 9, 9, 0),        9,  32'h2468_ACF0, EXC_CHK_NONE);
    add(32'hFC00_0000,                   9,  32'h2468_ACF0, EXC_CHK_RI);
    add(enc_i(6'h04, 8, 0, 16'h0005),    0,  32'h0000_0000, EXC_CHK_NONE);
    add(enc_i(6'h09, 0, 0, 16'h0007),    0,  32'h0000_0000, EXC_CHK_NONE);
    add(enc_i(6'h09, 0, 2, 16'h000A),    2,  32'h0000_000A, EXC_CHK_NONE);
    add(enc_r(6'h0C, 0, 0, 0, 0),        2,  32'h0000_000A, EXC_CHK_SYSCALL);

    prog.delete();
    foreach (vecs[i]) begin
      prog.push_back(vecs[i].instr);
      e.dst = vecs[i].dst; e.val = vecs[i].val; e.exc = vecs[i].exc; e.pc = 32'(i * 4);
      sb.push_back(e);
    end
    load(prog);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset pc", dut.unit_core.pc, 32'h0);
    chk("reset gprs nonzero", nonzero_gprs(), 0);
    reset = 1'b1;

    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("vec%0d exc_chk", k), 32'(dut.unit_core.pif_decode.signal_out.control.exc_chk), 32'(e.exc));
      chk($sformatf("vec%0d pc", k), dut.unit_core.pc, e.pc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d r%0d", k, e.dst), dut.unit_core.unit_decode.unit_rf.file[e.dst], e.val);
      @(negedge clk);
      k++;
    end

    // Asynchronous reset between clock edges clears PC and GPRs at once
    #2 reset = 1'b0;
    #1;
    chk("async reset pc", dut.unit_core.pc, 32'h0);
    chk("async reset gprs nonzero", nonzero_gprs(), 0);
    @(negedge clk);
    reset = 1'b1;
    chk("restart pc", dut.unit_core.pc, 32'h0);
    @(posedge clk);
    #1;
    chk("restart pc+4", dut.unit_core.pc, 32'h4);
    chk("restart r8", dut.unit_core.unit_decode.unit_rf.file[8], 32'h0000_7FFF);

    // Countdown loop: five BNE iterations, then fall through to SYSCALL
    prog.delete();
    prog.push_back(enc_i(6'h09, 0, 8, 16'd5));
    prog.push_back(enc_i(6'h09, 0, 10, 16'd0));
    prog.push_back(enc_i(6'h09, 8, 8, 16'hFFFF));
    prog.push_back(enc_i(6'h09, 10, 10, 16'd1));
    prog.push_back(enc_i(6'h05, 8, 0, 16'hFFFD));
    prog.push_back(enc_i(6'h09, 0, 11, 16'h0055));
    prog.push_back(enc_i(6'h09, 0, 2, 16'd10));
    prog.push_back(enc_r(6'h0C, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    load(prog);
    do_reset();
    run_sys(cyc, hit);
    chk("loop syscall reached", 32'(hit), 32'h1);
    chk("loop cycles", cyc, 19);
    chk("loop iterations", dut.unit_core.unit_decode.unit_rf.file[10], 32'd5);
    chk("loop counter", dut.unit_core.unit_decode.unit_rf.file[8], 32'd0);
    chk("loop fallthrough", dut.unit_core.unit_decode.unit_rf.file[11], 32'h55);
    chk("loop v0", dut.unit_core.unit_decode.unit_rf.file[2], 32'd10);

    // JAL/JR call and return, taken BEQ and J skipping code
    prog.delete();
    prog.push_back(enc_i(6'h09, 0, 4, 16'd3));
    prog.push_back(enc_j(6'h03, 26'd5));
    prog.push_back(enc_i(6'h09, 0, 5, 16'h0077));
    prog.push_back(enc_i(6'h04, 0, 0, 16'd3));
    prog.push_back(enc_i(6'h09, 0, 7, 16'd1));
    prog.push_back(enc_r(6'h21, 4, 4, 6, 0));
    prog.push_back(enc_r(6'h08, 31, 0, 0, 0));
    prog.push_back(enc_j(6'h02, 26'd10));
    prog.push_back(enc_i(6'h09, 0, 7, 16'd2));
    prog.push_back(32'h0);
    prog.push_back(enc_i(6'h09, 0, 2, 16'd10));
    prog.push_back(enc_r(6'h0C, 0, 0, 0, 0));
    reset = 1'b0;
    load(prog);
    do_reset();
    run_sys(cyc, hit);
    chk("call syscall reached", 32'(hit), 32'h1);
    chk("call cycles", cyc, 8);
    chk("call ra", dut.unit_core.unit_decode.unit_rf.file[31], 32'h8);
    chk("call body", dut.unit_core.unit_decode.unit_rf.file[6], 32'd6);
    chk("call resume", dut.unit_core.unit_decode.unit_rf.file[5], 32'h77);
    chk("call skipped", dut.unit_core.unit_decode.unit_rf.file[7], 32'h0);
    chk("call syscall pc", dut.unit_core.pc, 32'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
